// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage pipeline: derives stage write/bubble/flush controls
// from load-use, taken-branch and memory-wait conditions, plus stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]       FLUSH_LOAD = 4'(BRANCH_PENALTY - 1);
    localparam logic [15:0]      BUSY_LAST  = 16'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [15:0] busy_cnt;
    logic        load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign state = state_q;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        if (reset) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
        end else if (mem_busy) begin
            // Freeze the whole pipe; a pending branch flush just pauses.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            state_d      = (state_q == BR_FLUSH) ? BR_FLUSH : MEM_WAIT;
        end else if (state_q == BR_FLUSH) begin
            ifid_flush = 1'b1;
            fcnt_d     = fcnt_q - 4'd1;
            state_d    = (fcnt_q == 4'd1) ? RUN : BR_FLUSH;
        end else begin
            state_d = RUN;
            if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (BRANCH_PENALTY > 1) begin
                    state_d = BR_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            fcnt_q       <= 4'd0;
            busy_cnt     <= 16'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (mem_busy) begin
                // Hold at the threshold so long waits cannot wrap the counter.
                if (busy_cnt != BUSY_LAST)
                    busy_cnt <= busy_cnt + 16'd1;
                if (busy_cnt == BUSY_LAST)
                    mem_timeout <= 1'b1;
            end else begin
                busy_cnt <= 16'd0;
            end
            if (!pc_write && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (ifid_flush && flush_cycles != CNT_MAX)
                flush_cycles <= flush_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl, checked against a
// cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int P     = 2;
    localparam int MT    = 4;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic             exmem_write, memwb_bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    // model state
    int flush_left = 0;
    bit in_wait    = 0;
    int busy_run   = 0;
    bit m_timeout  = 0;
    int m_stalls   = 0;
    int m_flushes  = 0;

    pipeline_hazard_ctrl #(.BRANCH_PENALTY(P), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_bubble(idex_bubble),
        .exmem_write(exmem_write), .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit rd, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input bit urt, input bit br, input bit busy);
        reset = rst; ex_mem_read = rd; ex_rt = ert; id_rs = rs; id_rt = rt;
        id_uses_rt = urt; ex_branch_taken = br; mem_busy = busy;
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        bit lu;
        bit e_pc, e_ifw, e_fl, e_idw, e_bub, e_exw, e_mwb;
        int e_state;
        @(negedge clk);
        lu = ex_mem_read && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        e_pc = 1; e_ifw = 1; e_fl = 0; e_idw = 1; e_bub = 0; e_exw = 1; e_mwb = 0;
        if (!reset) begin
            if (mem_busy) begin
                e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_mwb = 1;
            end else if (flush_left > 0) begin
                e_fl = 1;
            end else if (ex_branch_taken) begin
                e_fl = 1; e_bub = 1;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_bub = 1;
            end
        end
        e_state = (flush_left > 0) ? 1 : (in_wait ? 2 : 0);
        check("pc_write",     32'(pc_write),     32'(e_pc));
        check("ifid_write",   32'(ifid_write),   32'(e_ifw));
        check("ifid_flush",   32'(ifid_flush),   32'(e_fl));
        check("idex_write",   32'(idex_write),   32'(e_idw));
        check("idex_bubble",  32'(idex_bubble),  32'(e_bub));
        check("exmem_write",  32'(exmem_write),  32'(e_exw));
        check("memwb_bubble", 32'(memwb_bubble), 32'(e_mwb));
        check("state",        32'(state),        32'(e_state));
        check("mem_timeout",  32'(mem_timeout),  32'(m_timeout));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        check("flush_cycles", 32'(flush_cycles), 32'(m_flushes));
        @(posedge clk);
        if (reset) begin
            flush_left = 0; in_wait = 0; busy_run = 0; m_timeout = 0;
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (!e_pc && m_stalls < CMAX) m_stalls++;
            if (e_fl && m_flushes < CMAX) m_flushes++;
            if (mem_busy) begin
                busy_run++;
                if (busy_run >= MT) m_timeout = 1;
            end else begin
                busy_run = 0;
            end
            if (mem_busy) begin
                in_wait = (flush_left == 0);
            end else begin
                in_wait = 0;
                if (flush_left > 0) flush_left--;
                else if (ex_branch_taken) flush_left = P - 1;
            end
        end
        #1;
    endtask

    initial begin
        bit busy_prev = 0;
        bit rd, br, busy, rst, urt;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();

        // load-use on rs
        drive(0, 1, 8, 8, 0, 0, 0, 0); cycle();
        check("t1_stall_cnt", 32'(stall_cycles), 32'd1);
        // ex_rt = 0 never stalls
        drive(0, 1, 0, 0, 0, 0, 0, 0); cycle();
        check("t2_stall_cnt", 32'(stall_cycles), 32'd1);
        // taken branch, penalty 2
        drive(0, 0, 0, 0, 0, 0, 1, 0); cycle();
        check("t3_state_flush", 32'(state), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        check("t3_flush_cnt", 32'(flush_cycles), 32'd2);
        check("t3_state_run", 32'(state), 32'd0);
        // branch beats load-use
        drive(0, 1, 5, 5, 0, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        // freeze during BR_FLUSH
        drive(0, 0, 0, 0, 0, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle(); cycle(); cycle();
        check("t5_state_paused", 32'(state), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        check("t5_state_done", 32'(state), 32'd0);
        check("t5_flush_cnt", 32'(flush_cycles), 32'd6);
        // timeout after 4 busy edges, sticky until reset
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle(); cycle(); cycle();
        check("t6_no_timeout", 32'(mem_timeout), 32'd0);
        cycle();
        check("t6_timeout", 32'(mem_timeout), 32'd1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        check("t6_sticky", 32'(mem_timeout), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 1); cycle();
        check("t6_rst_timeout", 32'(mem_timeout), 32'd0);
        check("t6_rst_stall", 32'(stall_cycles), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            rd   = ($urandom_range(0, 99) < 45);
            br   = ($urandom_range(0, 99) < 15);
            urt  = $urandom_range(0, 1) == 1;
            busy = busy_prev ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 15);
            busy_prev = busy;
            drive(rst, rd, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), urt, br, busy);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
